// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - debounced run/pause controller with programmable tick generator
module tick_ctrl #(
    parameter int               CNT_W          = 26,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 26'd50000000,
    parameter int               DEB_W          = 20,
    parameter int               DEB_MAX        = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             load_i,
    output logic             tick_o,
    output logic             run_o,
    output logic [CNT_W-1:0] cnt_o
);

    // Last debounce count before a differing level is accepted.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    logic             btn_meta;
    logic             btn_s;
    logic             deb_lvl;
    logic             deb_d;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    logic [CNT_W-1:0] period_reg;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             tick_n;

    // Two-flop synchronizer bringing the raw button into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_i;
            btn_s    <= btn_meta;
        end
    end

    // Accept a new button level only after it differs for DEB_MAX consecutive cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_lvl <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == deb_lvl) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_lvl <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_d <= 1'b0;
        end else begin
            deb_d <= deb_lvl;
        end
    end

    // One-cycle press event on the debounced rising edge; release is ignored.
    assign press = deb_lvl & ~deb_d;

    // Period register, reloadable in any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_reg <= DEFAULT_PERIOD;
        end else if (load_i) begin
            period_reg <= period_i;
        end
    end

    // Next-state, counter and tick decode; a load overrides any press.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tick_n  = (state == ST_RUN) && (cnt == period_reg) && !load_i;
        if (load_i) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt_n = '0;
                    if (press) begin
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Terminal count still wraps even when a press pauses us.
                    if (cnt == period_reg) begin
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                    if (press) begin
                        state_n = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (press) begin
                        state_n = ST_RUN;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; run_o tracks the state it is loaded with.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            tick_o <= 1'b0;
            run_o  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tick_o <= tick_n;
            run_o  <= (state_n == ST_RUN);
        end
    end

    assign cnt_o = cnt;

endmodule

// File: tb/tb_tick_ctrl.sv
// tb/tb_tick_ctrl.sv - directed and randomized checks of tick_ctrl against a reference model
module tb_tick_ctrl;

    localparam int CNT_W    = 8;
    localparam int DEB_W    = 4;
    localparam int DEB_MAX  = 4;
    localparam int DEF_P    = 3;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             btn_i = 1'b0;
    logic             load_i = 1'b0;
    logic [CNT_W-1:0] period_i = '0;
    logic             tick_o;
    logic             run_o;
    logic [CNT_W-1:0] cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_s1, m_s2;
    bit m_lvl, m_lvl_d;
    int m_mis;
    int m_mode;
    int m_cnt;
    int m_period;
    bit m_tick, m_run;

    always #5 clk = ~clk;

    tick_ctrl #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (8'd3),
        .DEB_W          (DEB_W),
        .DEB_MAX        (DEB_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_i),
        .period_i (period_i),
        .load_i   (load_i),
        .tick_o   (tick_o),
        .run_o    (run_o),
        .cnt_o    (cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_d = 0; m_mis = 0;
        m_mode = M_IDLE; m_cnt = 0; m_period = DEF_P; m_tick = 0; m_run = 0;
    endtask

    task automatic model_edge(input bit b, input bit ld, input int p);
        bit press;
        int nmode;
        int ncnt;
        bit ntick;
        press = m_lvl && !m_lvl_d;
        ntick = (m_mode == M_RUN) && (m_cnt == m_period) && !ld;
        nmode = m_mode;
        ncnt  = m_cnt;
        if (ld) begin
            nmode = M_IDLE;
            ncnt  = 0;
        end else begin
            if (m_mode == M_RUN) ncnt = (m_cnt == m_period) ? 0 : (m_cnt + 1) % 256;
            else if (m_mode == M_IDLE) ncnt = 0;
            if (press) nmode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
        end
        if (ld) m_period = p;
        m_lvl_d = m_lvl;
        // A level is accepted on the DEB_MAX-th consecutive disagreeing sample.
        if (m_s2 != m_lvl) begin
            m_mis++;
            if (m_mis == DEB_MAX) begin
                m_lvl = m_s2;
                m_mis = 0;
            end
        end else begin
            m_mis = 0;
        end
        m_s2   = m_s1;
        m_s1   = b;
        m_mode = nmode;
        m_cnt  = ncnt;
        m_tick = ntick;
        m_run  = (nmode == M_RUN);
    endtask

    task automatic compare();
        chk("tick_o", 32'(tick_o), 32'(m_tick));
        chk("run_o",  32'(run_o),  32'(m_run));
        chk("cnt_o",  32'(cnt_o),  32'(m_cnt));
    endtask

    task automatic step(input bit b, input bit ld, input int p);
        btn_i    = b;
        load_i   = ld;
        period_i = CNT_W'(p);
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(b, ld, p);
        #1;
        compare();
    endtask

    task automatic release_btn();
        for (int i = 0; i < 12; i++) step(0, 0, 0);
    endtask

    initial begin
        bit r_lvl;
        int r_len;
        bit r_ld;
        int r_p;
        bit found;
        int bounce [7];

        model_reset();

        // Reset held low for three cycles, then idle
        #1;
        compare();
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        // Short bounces must not start the controller
        bounce = '{1, 1, 0, 1, 1, 1, 0};
        for (int i = 0; i < 7; i++) step(bounce[i][0], 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("bounce_run", 32'(run_o), 32'd0);

        // Start: run_o rises at edge 7, first tick 4 cycles later
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0);
            if (i == 6) chk("start_before", 32'(run_o), 32'd0);
            if (i == 7) chk("start_at", 32'(run_o), 32'd1);
            if (i == 10) chk("start_no_tick", 32'(tick_o), 32'd0);
            if (i == 11) begin
                chk("first_tick", 32'(tick_o), 32'd1);
                chk("first_tick_cnt", 32'(cnt_o), 32'd0);
            end
        end
        release_btn();

        // Pause with cnt_o == 2 at the pressing edge
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_mode == M_RUN && m_cnt == 0) found = 1;
            else step(0, 0, 0);
        end
        chk("pause_align", 32'(found), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0);
            if (i >= 7) begin
                chk("pause_run", 32'(run_o), 32'd0);
                chk("pause_hold", 32'(cnt_o), 32'd3);
                chk("pause_tick", 32'(tick_o), 32'd0);
            end
        end
        release_btn();
        chk("pause_hold_late", 32'(cnt_o), 32'd3);

        // Resume from held count: tick on the next edge after resuming
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0);
            if (i == 7) chk("resume_run", 32'(run_o), 32'd1);
            if (i == 8) chk("resume_tick", 32'(tick_o), 32'd1);
        end
        release_btn();

        // Load coinciding with a debounced press
        for (int i = 1; i <= 6; i++) step(1, 0, 0);
        step(1, 1, 1);
        chk("load_run", 32'(run_o), 32'd0);
        chk("load_cnt", 32'(cnt_o), 32'd0);
        chk("load_tick", 32'(tick_o), 32'd0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        release_btn();
        chk("load_idle", 32'(run_o), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0);
            if (i == 9 || i == 11) chk("p1_tick", 32'(tick_o), 32'd1);
            if (i == 10) chk("p1_gap", 32'(tick_o), 32'd0);
        end
        release_btn();

        // Asynchronous reset mid-run with cnt_o == 2, period previously 5
        step(0, 1, 5);
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        release_btn();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_mode == M_RUN && m_cnt == 2) found = 1;
            else step(0, 0, 0);
        end
        chk("areset_align", 32'(found), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("areset_tick", 32'(tick_o), 32'd0);
        chk("areset_run", 32'(run_o), 32'd0);
        chk("areset_cnt", 32'(cnt_o), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0);
            if (i == 11) chk("areset_period", 32'(tick_o), 32'd1);
        end
        release_btn();

        // Randomized button activity with occasional period loads
        for (int n = 0; n < 80; n++) begin
            r_lvl = 1'($urandom_range(0, 1));
            r_len = $urandom_range(1, 10);
            for (int k = 0; k < r_len; k++) begin
                r_ld = ($urandom_range(0, 29) == 0);
                r_p  = $urandom_range(0, 5);
                step(r_lvl, r_ld, r_p);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
